// File: rtl/adc_capture_buf_if.sv
// Capture buffer bundle: capture control, ADC sample stream, status and read port.
// Latency: none, signal grouping only.
// Backpressure: none; the ADC stream is valid-only and reads are fire-and-forget.
interface adc_capture_buf_if #(
   parameter int DATA_WIDTH = 10,
   parameter int ADDR_WIDTH = 13
);
   logic                  start;
   logic                  abort;
   logic [7:0]            decim;
   logic                  adc_valid;
   logic [DATA_WIDTH-1:0] adc_data;
   logic                  busy;
   logic                  done;
   logic [ADDR_WIDTH-1:0] wr_count;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;

   // Controller/host side: issues commands, samples and reads.
   modport master (
      output start, abort, decim, adc_valid, adc_data, rd_en, rd_addr,
      input  busy, done, wr_count, rd_data, rd_valid
   );

   // Buffer side.
   modport slave (
      input  start, abort, decim, adc_valid, adc_data, rd_en, rd_addr,
      output busy, done, wr_count, rd_data, rd_valid
   );
endinterface

// File: rtl/adc_capture_buf.sv
// Captures decimated ADC samples into a single-port buffer, read back when not capturing.
// Latency: sample stored on the edge it is presented; read data 1 cycle after rd_en.
// Backpressure: none; samples outside CAPTURE and reads during CAPTURE are dropped.
module adc_capture_buf #(
   parameter int DATA_WIDTH = 10,
   parameter int DEPTH      = 5120,   // must not exceed 2**ADDR_WIDTH - 1
   parameter int ADDR_WIDTH = 13
) (
   input  logic           clk,
   input  logic           reset,
   adc_capture_buf_if.slave bus
);

   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_ADDR = ADDR_WIDTH'(DEPTH);

   typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
   logic [7:0]            decim_q;
   logic [7:0]            dec_cnt;
   logic [ADDR_WIDTH-1:0] wr_count;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  busy;
   logic                  done;
   logic                  arm;
   logic                  sample;
   logic                  wr_en;
   logic                  rd_go;
   logic [MEM_AW-1:0]     mem_addr;

   // State register; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state: abort beats start, filling the last slot ends the capture.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (bus.abort)      state_nxt = IDLE;
            else if (bus.start) state_nxt = CAPTURE;
         end
         CAPTURE: begin
            if (bus.abort)                           state_nxt = IDLE;
            else if (wr_en && wr_count == LAST_ADDR) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs and strobes; the memory port is shared, so the address follows
   // the write counter in CAPTURE and the read address otherwise.
   always_comb begin
      busy     = (state == CAPTURE);
      done     = (state == DONE);
      arm      = !busy && bus.start && !bus.abort;
      sample   = busy && bus.adc_valid && !bus.abort && !reset;
      wr_en    = sample && (dec_cnt == 8'd0);
      rd_go    = !busy && bus.rd_en && !reset;
      mem_addr = wr_en ? wr_count[MEM_AW-1:0] : bus.rd_addr[MEM_AW-1:0];
   end

   // Capture counters: decimation phase and stored-sample count.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_count <= '0;
         dec_cnt  <= 8'd0;
         decim_q  <= 8'd0;
      end else if (arm) begin
         wr_count <= '0;
         dec_cnt  <= 8'd0;
         decim_q  <= bus.decim;
      end else if (sample) begin
         dec_cnt <= (dec_cnt == decim_q) ? 8'd0 : dec_cnt + 8'd1;
         if (wr_en) wr_count <= wr_count + ADDR_WIDTH'(1);
      end
   end

   // Sample storage; contents survive reset on purpose.
   always_ff @(posedge clk) begin
      if (wr_en) mem[mem_addr] <= bus.adc_data;
   end

   // Registered read port; out-of-range addresses answer with zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_go;
         if (rd_go) rd_data <= (bus.rd_addr < DEPTH_ADDR) ? mem[mem_addr] : '0;
      end
   end

   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.wr_count = wr_count;
   assign bus.rd_data  = rd_data;
   assign bus.rd_valid = rd_valid;

endmodule

// File: tb/tb_adc_capture_buf.sv
// Bench for adc_capture_buf with DEPTH=8: capture, decimation, abort, reset and read port.
// Read responses are scoreboarded through a queue filled when each read is issued.
// Inputs driven 1 time unit after the rising edge; outputs sampled there or on the falling edge.
module tb_adc_capture_buf;
   localparam int DW    = 10;
   localparam int AW    = 13;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] model [0:DEPTH-1];

   adc_capture_buf_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   adc_capture_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [7:0] d, input logic with_abort);
      bus.start = 1'b1;
      bus.decim = d;
      bus.abort = with_abort;
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
   endtask

   task automatic pulse_abort();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
   endtask

   task automatic send(input logic [DW-1:0] v);
      bus.adc_valid = 1'b1;
      bus.adc_data  = v;
      tick();
      bus.adc_valid = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
      bus.rd_en   = 1'b1;
      bus.rd_addr = a;
      exp_q.push_back(e);
      tick();
      bus.rd_en = 1'b0;
      @(negedge clk);   // response cycle, consumed by the monitor
      @(negedge clk);
      chk("rd_once", 32'(bus.rd_valid), 32'd0);
      chk("rd_hold", 32'(bus.rd_data), 32'(e));
      chk("rd_lost", exp_q.size(), 32'd0);
   endtask

   // Read-side monitor: every rd_valid must match a queued expectation.
   always @(negedge clk) begin
      if (bus.rd_valid === 1'b1) begin
         if (exp_q.size() == 0) chk("rd_spurious", 32'(bus.rd_valid), 32'd0);
         else                   chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time %0t beyond limit 100000", $time);
      $fatal(1, "timeout");
   end

   initial begin
      bus.start = 1'b0; bus.abort = 1'b0; bus.decim = 8'd0;
      bus.adc_valid = 1'b0; bus.adc_data = '0;
      bus.rd_en = 1'b0; bus.rd_addr = '0;
      reset = 1'b1;
      tick(); tick();
      chk("rst_busy",  32'(bus.busy), 32'd0);
      chk("rst_done",  32'(bus.done), 32'd0);
      chk("rst_cnt",   32'(bus.wr_count), 32'd0);
      chk("rst_rdv",   32'(bus.rd_valid), 32'd0);
      chk("rst_rdd",   32'(bus.rd_data), 32'd0);
      reset = 1'b0;
      tick();

      // Full capture without decimation: 10 samples offered, 8 stored.
      pulse_start(8'd0, 1'b0);
      chk("t1_busy", 32'(bus.busy), 32'd1);
      chk("t1_cnt0", 32'(bus.wr_count), 32'd0);
      for (int k = 1; k <= 10; k++) begin
         send(DW'(k));
         if (k == 4) begin
            chk("t1_busy4", 32'(bus.busy), 32'd1);
            chk("t1_cnt4",  32'(bus.wr_count), 32'd4);
         end
         if (k == 8 || k == 10) begin
            chk("t1_busy8", 32'(bus.busy), 32'd0);
            chk("t1_done8", 32'(bus.done), 32'd1);
            chk("t1_cnt8",  32'(bus.wr_count), 32'd8);
         end
      end
      for (int i = 0; i < DEPTH; i++) model[i] = DW'(i + 1);
      for (int i = 0; i < DEPTH; i++) do_read(AW'(i), model[i]);
      do_read(AW'(8), '0);
      do_read(AW'(8191), '0);

      // Decimation by 3, decim changed after start, read attempt mid-capture.
      pulse_start(8'd2, 1'b0);
      bus.decim = 8'd0;
      for (int k = 0; k <= 8; k++) begin
         if (k == 4) begin
            bus.rd_en = 1'b1;
            bus.rd_addr = '0;
         end
         send(DW'(k));
         bus.rd_en = 1'b0;
         if (k == 4) chk("cap_rd_ign", 32'(bus.rd_valid), 32'd0);
      end
      chk("t2_cnt",  32'(bus.wr_count), 32'd3);
      chk("t2_busy", 32'(bus.busy), 32'd1);
      // Abort together with a sample that would otherwise be stored at address 3.
      bus.abort = 1'b1; bus.adc_valid = 1'b1; bus.adc_data = DW'(9);
      tick();
      bus.abort = 1'b0; bus.adc_valid = 1'b0;
      chk("ab_busy", 32'(bus.busy), 32'd0);
      chk("ab_done", 32'(bus.done), 32'd0);
      chk("ab_cnt",  32'(bus.wr_count), 32'd3);
      model[0] = DW'(0); model[1] = DW'(3); model[2] = DW'(6);
      for (int i = 0; i < 4; i++) do_read(AW'(i), model[i]);

      // Reset mid-capture; reset overrides a coincident sample, start and read.
      pulse_start(8'd0, 1'b0);
      for (int k = 0; k < 5; k++) send(DW'(100 + k));
      chk("t3_cnt5", 32'(bus.wr_count), 32'd5);
      reset = 1'b1; bus.start = 1'b1;
      bus.adc_valid = 1'b1; bus.adc_data = DW'(105);
      bus.rd_en = 1'b1; bus.rd_addr = AW'(1);
      tick();
      reset = 1'b0; bus.start = 1'b0; bus.adc_valid = 1'b0; bus.rd_en = 1'b0;
      chk("mr_busy", 32'(bus.busy), 32'd0);
      chk("mr_done", 32'(bus.done), 32'd0);
      chk("mr_cnt",  32'(bus.wr_count), 32'd0);
      chk("mr_rdv",  32'(bus.rd_valid), 32'd0);
      chk("mr_rdd",  32'(bus.rd_data), 32'd0);
      for (int k = 0; k < 5; k++) model[k] = DW'(100 + k);
      do_read(AW'(5), model[5]);
      do_read(AW'(6), model[6]);
      do_read(AW'(0), model[0]);
      pulse_start(8'd0, 1'b0);
      send(DW'(200));
      chk("t3_cnt1", 32'(bus.wr_count), 32'd1);
      pulse_abort();
      chk("t3_idle", 32'(bus.busy), 32'd0);
      model[0] = DW'(200);
      do_read(AW'(0), model[0]);
      do_read(AW'(1), model[1]);

      // DONE handling: start+abort returns to IDLE, start in CAPTURE is ignored.
      pulse_start(8'd0, 1'b0);
      for (int k = 0; k < 8; k++) send(DW'(10 + k));
      chk("t4_done", 32'(bus.done), 32'd1);
      pulse_start(8'd0, 1'b1);
      chk("sa_busy", 32'(bus.busy), 32'd0);
      chk("sa_done", 32'(bus.done), 32'd0);
      chk("sa_cnt",  32'(bus.wr_count), 32'd8);
      pulse_start(8'd0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         if (k == 4) bus.start = 1'b1;
         send(DW'(20 + k));
         bus.start = 1'b0;
      end
      chk("t4_done2", 32'(bus.done), 32'd1);
      chk("t4_cnt2",  32'(bus.wr_count), 32'd8);
      for (int i = 0; i < DEPTH; i++) model[i] = DW'(20 + i);
      for (int i = 0; i < DEPTH; i++) do_read(AW'(i), model[i]);
      pulse_start(8'd0, 1'b0);
      chk("rs_busy", 32'(bus.busy), 32'd1);
      chk("rs_done", 32'(bus.done), 32'd0);
      chk("rs_cnt",  32'(bus.wr_count), 32'd0);
      pulse_abort();
      tick();

      chk("q_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/adc_capture_buf.md
ADC_CAPTURE_BUF -- requirements
Module: adc_capture_buf

Interface
REQ-001 Parameter DATA_WIDTH, default 10, sample width in bits.
REQ-002 Parameter DEPTH, default 5120, sample capacity; SHALL satisfy DEPTH <= 2**ADDR_WIDTH - 1.
REQ-003 Parameter ADDR_WIDTH, default 13, width of address and count ports.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to begin a capture.
REQ-007 abort  in  1  single-cycle request to end a capture early.
REQ-008 decim  in  8  decimation: store 1 of every decim+1 valid samples; sampled when start is accepted.
REQ-009 adc_valid  in  1  adc_data is valid this cycle.
REQ-010 adc_data  in  DATA_WIDTH  ADC sample.
REQ-011 busy  out  1  high while in CAPTURE.
REQ-012 done  out  1  high while in DONE.
REQ-013 wr_count  out  ADDR_WIDTH  number of samples stored in the current/last capture.
REQ-014 rd_en  in  1  read request.
REQ-015 rd_addr  in  ADDR_WIDTH  read address.
REQ-016 rd_data  out  DATA_WIDTH  read data.
REQ-017 rd_valid  out  1  rd_data is valid this cycle.

Function
REQ-018 The FSM SHALL have states IDLE, CAPTURE and DONE.
REQ-019 IDLE/DONE + start (and no abort) -> CAPTURE next cycle; wr_count cleared to 0, decimation counter cleared to 0, decim latched.
REQ-020 start SHALL be ignored in CAPTURE.
REQ-021 CAPTURE + abort -> IDLE next cycle; wr_count holds its value; a sample presented in the same cycle SHALL NOT be stored.
REQ-022 start and abort in the same cycle: abort wins; from IDLE/DONE the state SHALL become IDLE.
REQ-023 In CAPTURE, each adc_valid cycle SHALL increment the decimation counter modulo (latched decim + 1); the sample SHALL be written to address wr_count only when the counter is 0, and wr_count SHALL then increment.
REQ-024 The first adc_valid considered SHALL be the cycle after start is accepted.
REQ-025 A write to address DEPTH-1 SHALL move CAPTURE -> DONE on the next cycle, with wr_count = DEPTH; no further writes; no wrap-around.
REQ-026 The block SHALL use single-port storage; reads SHALL be serviced only in IDLE or DONE.
REQ-027 Read latency SHALL be 1 cycle: rd_en at cycle N -> rd_valid=1 and rd_data=mem[rd_addr] at cycle N+1; rd_valid=0 otherwise.
REQ-028 rd_en in CAPTURE SHALL be ignored (rd_valid stays 0, no write is disturbed).
REQ-029 rd_en with rd_addr >= DEPTH SHALL give rd_valid=1, rd_data=0.
REQ-030 rd_data SHALL hold its last value when rd_valid=0.
REQ-031 Reading addresses >= wr_count SHALL return stale contents; no clearing.

Reset
REQ-032 reset SHALL force IDLE with busy=0, done=0, wr_count=0, rd_valid=0, rd_data=0, decimation counter=0 on the next edge, including mid-capture.
REQ-033 reset SHALL take priority over start, abort, adc_valid and rd_en.
REQ-034 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-035 DEPTH=8, decim=0, start, then 10 adc_valid with data 1..10 -> busy for 8 samples, done=1, wr_count=8; reads of 0..7 return 1..8; address 8 returns 0 with rd_valid=1.
REQ-036 decim=2, 9 valid samples of data 0..8 -> stored 0,3,6; wr_count=3 with capture still busy.
REQ-037 Abort after 3 stored samples, coincident with a 4th adc_valid -> IDLE, wr_count=3, 4th sample not stored.
REQ-038 rd_en during CAPTURE -> rd_valid stays 0 and capture data is intact on later read; rd_en in DONE at cycle N -> rd_valid at N+1 only.
REQ-039 reset mid-capture after 5 samples -> next cycle IDLE, wr_count=0; a new start then captures from address 0; an old sample at address 6 is still readable before being overwritten.
REQ-040 start+abort together in DONE -> IDLE, wr_count unchanged; start alone in DONE -> CAPTURE, wr_count=0.
